// File: rtl/polyz_unpack_seq_pkg.sv
// Shared constants, FSM encoding and field-to-coefficient helper for the streaming polyz unpacker.
package polyz_unpack_seq_pkg;

    localparam int N           = 256;
    localparam int L_MAX       = 7;
    localparam int POLY_W      = $clog2(L_MAX + 1);
    localparam int GROUP_BYTES = 5;
    localparam int POLYZ_BYTES = 640;
    localparam int PAIRS       = POLYZ_BYTES / GROUP_BYTES;

    localparam logic [31:0] GAMMA1    = 32'd524288;
    localparam logic [6:0]  LAST_PAIR = 7'(PAIRS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT0,
        S_EMIT1,
        S_DONE
    } state_t;

    function automatic logic [31:0] coef_of(input logic [19:0] field);
        return GAMMA1 - {12'd0, field};
    endfunction

endpackage

// File: rtl/polyz_pair_unpack.sv
// One 5-byte group -> two signed coefficients (GAMMA1 - 20-bit field); purely combinational,
// no latency, no flow control.
module polyz_pair_unpack
    import polyz_unpack_seq_pkg::*;
(
    input  logic [39:0] grp,
    output logic [31:0] coef_lo,
    output logic [31:0] coef_hi
);

    assign coef_lo = coef_of(grp[19:0]);
    assign coef_hi = coef_of(grp[39:20]);

endmodule

// File: rtl/polyz_unpack_seq.sv
// Byte-stream polyz unpacker: 5 bytes in, then two coefficients out; first coefficient one cycle
// after the 5th byte. in_ready only while collecting; output holds until out_ready.
module polyz_unpack_seq
    import polyz_unpack_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        num_polys,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [2:0]        out_poly,
    output logic [7:0]        out_idx,
    output logic              busy,
    output logic              done
);

    state_t             state, state_nxt;
    logic [2:0]         byte_cnt;
    logic [6:0]         pair_cnt;
    logic [POLY_W-1:0]  poly_cnt;
    logic [POLY_W-1:0]  np_reg;
    logic [39:0]        grp;
    logic [31:0]        coef_lo, coef_hi;
    logic               last_pair, last_poly;

    polyz_pair_unpack u_pair_unpack (
        .grp     (grp),
        .coef_lo (coef_lo),
        .coef_hi (coef_hi)
    );

    assign last_pair = (pair_cnt == LAST_PAIR);
    assign last_poly = (poly_cnt == np_reg - 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are decoded from state so an async reset clears them without waiting for a clock.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 32'd0;
        out_poly  = 3'd0;
        out_idx   = 8'd0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_polys != 3'd0) ? S_COLLECT : S_DONE;
                end
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && byte_cnt == 3'(GROUP_BYTES - 1)) begin
                    state_nxt = S_EMIT0;
                end
            end
            S_EMIT0: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = coef_lo;
                out_poly  = poly_cnt;
                out_idx   = {pair_cnt, 1'b0};
                if (out_ready) begin
                    state_nxt = S_EMIT1;
                end
            end
            S_EMIT1: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = coef_hi;
                out_poly  = poly_cnt;
                out_idx   = {pair_cnt, 1'b1};
                if (out_ready) begin
                    state_nxt = (last_pair && last_poly) ? S_DONE : S_COLLECT;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 3'd0;
            pair_cnt <= 7'd0;
            poly_cnt <= '0;
            np_reg   <= '0;
            grp      <= 40'd0;
        end else begin
            if (state == S_IDLE && start) begin
                np_reg   <= num_polys;
                byte_cnt <= 3'd0;
                pair_cnt <= 7'd0;
                poly_cnt <= '0;
            end
            if (in_ready && in_valid) begin
                for (int k = 0; k < GROUP_BYTES; k++) begin
                    if (byte_cnt == 3'(k)) begin
                        grp[8*k +: 8] <= in_data;
                    end
                end
                byte_cnt <= (byte_cnt == 3'(GROUP_BYTES - 1)) ? 3'd0 : byte_cnt + 3'd1;
            end
            if (state == S_EMIT1 && out_ready) begin
                if (last_pair) begin
                    pair_cnt <= 7'd0;
                    poly_cnt <= poly_cnt + 3'd1;
                end else begin
                    pair_cnt <= pair_cnt + 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_polyz_unpack_seq.sv
// Scoreboard bench: expected coefficients computed from the byte array with plain arithmetic.
module tb_polyz_unpack_seq;
    import polyz_unpack_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  num_polys = 3'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_poly;
    logic [7:0]  out_idx;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    polyz_unpack_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_polys (num_polys),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_poly  (out_poly),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  p;
        logic [7:0]  i;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem[0:4479];
    logic [31:0] out_log[0:8191];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int in_cnt = 0, out_cnt = 0, done_cnt = 0;
    int last_out_cyc = 0, last_done_cyc = 0, hs5_cyc = 0;
    int ov_job = -1, job_id = 0, job_in_base = 0, job_np = 0;
    bit lat_check = 0;

    logic        pv = 1'b0, pr = 1'b0, prev_done = 1'b0;
    logic [31:0] hd = 32'd0;
    logic [2:0]  hp = 3'd0;
    logic [7:0]  hi = 8'd0;

    function automatic void chk(input bit ok, input string name, input logic [63:0] act,
                                input logic [63:0] expv);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: samples at negedge; a valid&&ready seen here completes on the next posedge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            pv = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (pv && !pr)
                chk({out_valid, out_data, out_poly, out_idx} == {1'b1, hd, hp, hi}, "hold_stable",
                    {out_valid, out_data, out_poly, out_idx}, {1'b1, hd, hp, hi});
            if (out_valid) begin
                chk(!in_ready, "no_overlap", in_ready, 0);
                if (ov_job != job_id) begin
                    ov_job = job_id;
                    if (lat_check) chk(cyc == hs5_cyc + 1, "first_latency", cyc, hs5_cyc + 1);
                end
            end
            if (in_valid && in_ready) begin
                in_cnt++;
                if (in_cnt - job_in_base == 5) hs5_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                chk(exp_q.size() != 0, "sb_nonempty", exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk({out_data, out_poly, out_idx} == e, "coef",
                        {out_data, out_poly, out_idx}, e);
                end
                out_log[out_cnt % 8192] = out_data;
                out_cnt++;
                last_out_cyc = cyc;
            end
            if (done) begin
                chk(!busy, "busy_low_at_done", busy, 0);
                chk(!prev_done, "done_single", prev_done, 0);
                if (job_np != 0) chk(cyc == last_out_cyc + 1, "done_timing", cyc, last_out_cyc + 1);
                done_cnt++;
                last_done_cyc = cyc;
            end
            prev_done = done;
            pv = out_valid;
            pr = out_ready;
            hd = out_data;
            hp = out_poly;
            hi = out_idx;
        end
    end

    task automatic fill_random();
        for (int k = 0; k < 4480; k++) mem[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic run_job(input int np, input bit gaps, input bit stalls, input bit poke,
                           input bit lat);
        int   nb, i, tries, tries2, c0, d0;
        bit   hs;
        longint v;
        exp_t e;
        nb = np * POLYZ_BYTES;
        for (int p = 0; p < np; p++) begin
            for (int j = 0; j < 128; j++) begin
                v = 0;
                for (int k = 4; k >= 0; k--) v = v * 256 + longint'(mem[p * 640 + j * 5 + k]);
                e.p = 3'(p);
                e.d = 32'(longint'(524288) - (v % 1048576));
                e.i = 8'(2 * j);
                exp_q.push_back(e);
                e.d = 32'(longint'(524288) - (v / 1048576));
                e.i = 8'(2 * j + 1);
                exp_q.push_back(e);
            end
        end
        job_id++;
        job_np = np;
        job_in_base = in_cnt;
        lat_check = lat;
        d0 = done_cnt;
        @(posedge clk); #2;
        start = 1'b1;
        num_polys = 3'(np);
        c0 = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        fork
            begin
                i = 0;
                tries = 0;
                while (i < nb && tries < 60000) begin
                    in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                    in_data = mem[i];
                    @(negedge clk);
                    hs = in_valid && in_ready;
                    @(posedge clk); #2;
                    if (hs) i++;
                    tries++;
                end
                if (nb != 0) begin
                    in_valid = 1'b0;
                    chk(i == nb, "bytes_fed", i, nb);
                end
            end
            begin
                tries2 = 0;
                while ((exp_q.size() != 0 || done_cnt == d0) && tries2 < 60000) begin
                    out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
                    @(posedge clk); #2;
                    tries2++;
                end
                chk(tries2 < 60000, "job_timeout", tries2, 60000);
            end
            begin
                if (poke) begin
                    repeat (600) @(posedge clk);
                    #2;
                    start = 1'b1;
                    num_polys = 3'd1;
                    @(posedge clk); #2;
                    start = 1'b0;
                end
            end
        join
        repeat (2) @(posedge clk);
        #2;
        chk(done_cnt == d0 + 1, "done_count", done_cnt - d0, 1);
        chk(in_cnt - job_in_base == nb, "in_count", in_cnt - job_in_base, nb);
        chk(exp_q.size() == 0, "sb_drained", exp_q.size(), 0);
        if (np == 0)
            chk(last_done_cyc - c0 >= 1 && last_done_cyc - c0 <= 2, "zero_job_done_time",
                last_done_cyc - c0, 1);
    endtask

    initial begin
        int   base, base2, nmis, i, tries;
        bit   hs;
        #12;
        chk({in_ready, out_valid, out_data, out_poly, out_idx, busy, done} == 47'd0,
            "reset_state", {in_ready, out_valid, out_data, out_poly, out_idx, busy, done}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Directed groups at the head of a single-polynomial job.
        fill_random();
        for (int k = 0; k < 20; k++) mem[k] = 8'h00;
        for (int k = 5; k < 10; k++) mem[k] = 8'hFF;
        mem[10] = 8'h01;
        mem[17] = 8'h10;
        base = out_cnt;
        run_job(1, 0, 0, 0, 1);
        chk(out_log[base + 0] == 32'h00080000, "zero_c0", out_log[base + 0], 32'h00080000);
        chk(out_log[base + 1] == 32'h00080000, "zero_c1", out_log[base + 1], 32'h00080000);
        chk(out_log[base + 2] == 32'hFFF80001, "ones_c0", out_log[base + 2], 32'hFFF80001);
        chk(out_log[base + 3] == 32'hFFF80001, "ones_c1", out_log[base + 3], 32'hFFF80001);
        chk(out_log[base + 4] == 32'h0007FFFF, "nib_lo_c0", out_log[base + 4], 32'h0007FFFF);
        chk(out_log[base + 5] == 32'h00080000, "nib_lo_c1", out_log[base + 5], 32'h00080000);
        chk(out_log[base + 6] == 32'h00080000, "nib_hi_c0", out_log[base + 6], 32'h00080000);
        chk(out_log[base + 7] == 32'h0007FFFF, "nib_hi_c1", out_log[base + 7], 32'h0007FFFF);

        // Same 5-polynomial stream without and with stalls; start poked while busy in the second.
        fill_random();
        base = out_cnt;
        run_job(5, 0, 0, 0, 1);
        base2 = out_cnt;
        run_job(5, 1, 1, 1, 0);
        nmis = 0;
        for (int k = 0; k < 1280; k++)
            if (out_log[(base + k) % 8192] !== out_log[(base2 + k) % 8192]) nmis++;
        chk(nmis == 0 && base2 - base == 1280, "stall_vs_nostall", nmis, 0);

        // Zero-polynomial job with a byte on offer: nothing may be consumed.
        in_valid = 1'b1;
        in_data = 8'hA5;
        run_job(0, 0, 0, 0, 0);
        in_valid = 1'b0;

        // Abort in EMIT0 via async reset, then a fresh job.
        job_id++;
        job_np = 1;
        lat_check = 0;
        job_in_base = in_cnt;
        out_ready = 1'b0;
        @(posedge clk); #2;
        start = 1'b1;
        num_polys = 3'd1;
        @(posedge clk); #2;
        start = 1'b0;
        i = 0;
        tries = 0;
        while (i < 5 && tries < 100) begin
            in_valid = 1'b1;
            in_data = 8'($urandom_range(0, 255));
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #2;
            if (hs) i++;
            tries++;
        end
        in_valid = 1'b0;
        tries = 0;
        while (!out_valid && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        chk(out_valid == 1'b1, "emit0_reached", out_valid, 1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk({in_ready, out_valid, out_data, out_poly, out_idx, busy, done} == 47'd0,
            "async_reset", {in_ready, out_valid, out_data, out_poly, out_idx, busy, done}, 0);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        fill_random();
        run_job(1, 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
